boss_ctrl: RTL

BOSS_CTRL -- requirements
Module: boss_ctrl

---
 rtl/boss_pkg.sv | 32 +++
 rtl/boss_ctrl_if.sv | 22 ++
 rtl/boss_hit_detect.sv | 36 +++
 rtl/boss_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boss_pkg.sv
// boss_pkg: shared state encoding, screen constants
// and a distance helper for the boss controller.
package boss_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FLOOR_ROW = 416;
  localparam int COORD_W   =
    $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REST      = 3'd1,
    S_RUSH_L    = 3'd2,
    S_RUSH_R    = 3'd3,
    S_JUMP      = 3'd4,
    S_BOMB_REQ  = 3'd5,
    S_BOMB_WAIT = 3'd6,
    S_DEAD      = 3'd7
  } state_e;

  // Unsigned distance; callers zero-extend so it never wraps.
  function automatic logic [COORD_W:0] absdiff(
    input logic [COORD_W:0] a,
    input logic [COORD_W:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/boss_ctrl_if.sv
// boss_ctrl_if: player-bullet bus (packed centres, live
// flags) and the per-channel hit acknowledge back.
interface boss_ctrl_if #(
  parameter int N = 4
) ();

  logic [10*N-1:0] bullet_X;
  logic [10*N-1:0] bullet_Y;
  logic [N-1:0]    bullet_valid;
  logic [N-1:0]    hit_ack;

  modport master (
    output bullet_X, bullet_Y, bullet_valid,
    input  hit_ack
  );

  modport slave (
    input  bullet_X, bullet_Y, bullet_valid,
    output hit_ack
  );

endinterface

// File: rtl/boss_hit_detect.sv
// boss_hit_detect: per-channel hitbox test against the boss
// centre; outputs hit vector, lowest-index one-hot, any flag.
module boss_hit_detect
  import boss_pkg::*;
#(
  parameter int N         = 4,
  parameter int HALF_SIZE = 32
) (
  input  logic [10*N-1:0] bx_i,
  input  logic [10*N-1:0] by_i,
  input  logic [N-1:0]    valid_i,
  input  coord_t          boss_x_i,
  input  coord_t          boss_y_i,
  output logic [N-1:0]    hit_o,
  output logic [N-1:0]    first_o,
  output logic            any_o
);

  localparam logic [COORD_W:0] HS = (COORD_W+1)'(HALF_SIZE);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < N; i++) begin
      hit_o[i] = valid_i[i]
        && (absdiff({1'b0, bx_i[10*i +: 10]},
                    {1'b0, boss_x_i}) <= HS)
        && (absdiff({1'b0, by_i[10*i +: 10]},
                    {1'b0, boss_y_i}) <= HS);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign first_o = hit_o & (-hit_o);
  assign any_o   = |hit_o;

endmodule

// File: rtl/boss_ctrl.sv
// boss_ctrl: boss movement FSM (rush/jump/bomb/rest), bullet
// hits, life, invulnerability blink and kid contact flag.
module boss_ctrl
  import boss_pkg::*;
#(
  parameter int N_BULLETS     = 4,
  parameter int LIFE_INIT     = 10,
  parameter int HALF_SIZE     = 32,
  parameter int INVULN_FRAMES = 150,
  parameter int BLINK_PERIOD  = 4,
  parameter int RUSH_ACCEL    = 2,
  parameter int RUSH_MAX      = 30,
  parameter int X_MIN         = 32,
  parameter int X_MAX         = 607,
  parameter int FLOOR_Y       = FLOOR_ROW,
  parameter int JUMP_V        = 20,
  parameter int GRAVITY       = 2,
  parameter int JUMP_TRIG_Y   = 350,
  parameter int BOMB_TRIG_Y   = 400,
  parameter int REST_FRAMES   = 20,
  parameter int BOMB_TIMEOUT  = 255
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  coord_t      Kid_position_X,
  input  coord_t      Kid_position_Y,
  input  logic        NoBomb,
  boss_ctrl_if.slave  bus,
  output coord_t      Boss_position_X,
  output coord_t      Boss_position_Y,
  output logic        shoot,
  output logic        hitKid,
  output logic        invuln,
  output logic        blink,
  output logic [7:0]  life,
  output logic [2:0]  boss_state,
  output logic        Boss_dead
);

  localparam int W = COORD_W + 1;
  localparam coord_t XMIN_C = coord_t'(X_MIN);
  localparam coord_t XMAX_C = coord_t'(X_MAX);
  localparam coord_t FLR_C  = coord_t'(FLOOR_Y);
  localparam coord_t ACC_C  = coord_t'(RUSH_ACCEL);
  localparam coord_t MAX_C  = coord_t'(RUSH_MAX);
  localparam logic [W-1:0] HS_C  = W'(HALF_SIZE);
  localparam logic [W-1:0] JT_C  = W'(JUMP_TRIG_Y);
  localparam logic [W-1:0] BTY_C = W'(BOMB_TRIG_Y);
  localparam logic signed [10:0] JV_C = 11'(-JUMP_V);
  localparam logic signed [10:0] GR_C = 11'(GRAVITY);
  localparam logic signed [11:0] FLR_S = 12'(FLOOR_Y);
  localparam logic [7:0] LIFE_C = 8'(LIFE_INIT);
  localparam logic [7:0] INV_C  = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLK_C  = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0] REST_C = 8'(REST_FRAMES);
  localparam logic [7:0] BTO_C  = 8'(BOMB_TIMEOUT - 1);

  state_e state_q, state_d;
  coord_t x_q, x_d, y_q, y_d, spd_q, spd_d;
  logic signed [10:0] vy_q, vy_d;
  logic [7:0] tmr_q, tmr_d, life_q, life_d;
  logic [7:0] inv_q, inv_d, bcnt_q, bcnt_d;
  logic blink_q, blink_d, hitkid_q, hitkid_d;
  logic [N_BULLETS-1:0] ack_q, ack_d;
  logic [N_BULLETS-1:0] hit_vec, hit_first;
  logic hit_any;

  boss_hit_detect #(
    .N         (N_BULLETS),
    .HALF_SIZE (HALF_SIZE)
  ) u_hit (
    .bx_i     (bus.bullet_X),
    .by_i     (bus.bullet_Y),
    .valid_i  (bus.bullet_valid),
    .boss_x_i (x_q),
    .boss_y_i (y_q),
    .hit_o    (hit_vec),
    .first_o  (hit_first),
    .any_o    (hit_any)
  );

  logic [W-1:0] ky15, kx16, ky16;
  logic kid_left, kid_ovl, land, accept, kill;
  logic jump_trig, bomb_trig;
  coord_t room_l, room_r, spd_up;
  logic signed [11:0] y_sum;

  assign ky15 = {1'b0, Kid_position_Y} + W'(15);
  assign kx16 = {1'b0, Kid_position_X} + W'(16);
  assign ky16 = {1'b0, Kid_position_Y} + W'(16);
  assign jump_trig = ky15 < JT_C;
  assign bomb_trig = ky15 < BTY_C;
  assign kid_left = Kid_position_X <= x_q;
  assign kid_ovl = (absdiff(kx16, {1'b0, x_q}) <= HS_C)
                && (absdiff(ky16, {1'b0, y_q}) <= HS_C);
  assign room_l = x_q - XMIN_C;
  assign room_r = XMAX_C - x_q;
  assign spd_up = (spd_q + ACC_C > MAX_C)
                ? MAX_C : spd_q + ACC_C;
  assign y_sum = $signed({2'b00, y_q})
               + $signed({vy_q[10], vy_q});
  assign land = (vy_q > 11'sd0) && (y_sum >= FLR_S);
  assign accept = hit_any && (inv_q == '0)
               && (state_q != S_DEAD);
  assign kill = accept && (life_q == 8'd1);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= XMAX_C;
      y_q      <= FLR_C;
      spd_q    <= '0;
      vy_q     <= '0;
      tmr_q    <= '0;
      life_q   <= LIFE_C;
      inv_q    <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b1;
      hitkid_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      spd_q    <= spd_d;
      vy_q     <= vy_d;
      tmr_q    <= tmr_d;
      life_q   <= life_d;
      inv_q    <= inv_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      hitkid_q <= hitkid_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    vy_d    = vy_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (jump_trig) begin
          state_d = S_JUMP;
          vy_d    = JV_C;
        end else if (bomb_trig) begin
          state_d = S_BOMB_REQ;
        end else begin
          state_d = kid_left ? S_RUSH_L : S_RUSH_R;
          spd_d   = ACC_C;
        end
      end
      S_RUSH_L: begin
        if (spd_q >= room_l) begin
          x_d     = XMIN_C;
          state_d = S_REST;
          tmr_d   = REST_C;
        end else begin
          x_d   = x_q - spd_q;
          spd_d = spd_up;
        end
      end
      S_RUSH_R: begin
        if (spd_q >= room_r) begin
          x_d     = XMAX_C;
          state_d = S_REST;
          tmr_d   = REST_C;
        end else begin
          x_d   = x_q + spd_q;
          spd_d = spd_up;
        end
      end
      S_JUMP: begin
        if (land) begin
          y_d     = FLR_C;
          vy_d    = '0;
          state_d = kid_left ? S_RUSH_L : S_RUSH_R;
          spd_d   = ACC_C;
        end else begin
          y_d  = coord_t'(y_sum);
          vy_d = vy_q + GR_C;
        end
      end
      S_BOMB_REQ: begin
        state_d = S_BOMB_WAIT;
        tmr_d   = '0;
      end
      S_BOMB_WAIT: begin
        if (NoBomb || tmr_q == BTO_C) begin
          state_d = S_REST;
          tmr_d   = REST_C;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_REST: begin
        // Leave on the frame the count reaches zero.
        if (tmr_q <= 8'd1) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_DEAD: state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_DEAD;
  end

  always_comb begin
    life_d  = accept ? life_q - 8'd1 : life_q;
    ack_d   = (accept && !kill)
            ? (hit_first & hit_vec) : '0;
    inv_d   = (inv_q != '0) ? inv_q - 8'd1 : '0;
    if (accept && !kill) inv_d = INV_C;
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (accept || inv_d == '0) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BLK_C) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + 8'd1;
    end
    hitkid_d = kid_ovl && (state_d != S_DEAD);
  end

  always_comb begin
    Boss_position_X = x_q;
    Boss_position_Y = y_q;
    shoot       = (state_q == S_BOMB_REQ);
    Boss_dead   = (state_q == S_DEAD);
    invuln      = (inv_q != '0);
    blink       = blink_q;
    life        = life_q;
    boss_state  = state_q;
    hitKid      = hitkid_q;
    bus.hit_ack = ack_q;
  end

endmodule
